// File: rtl/icache_refill_pkg.sv
// Shared frontend constants and the refill FSM state type.
// Geometry defaults and the line-offset width derived from the bank count.
package icache_refill_pkg;

  localparam int ICACHE_WAY       = 4;
  localparam int ICACHE_BANK      = 8;
  localparam int ICACHE_SET_WIDTH = 6;
  localparam int ICACHE_TAG       = 21;
  localparam int ICACHE_OFFSET    = $clog2(ICACHE_BANK * 4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_WRITE,
    ST_FLUSH
  } state_e;

  function automatic logic [31:0] line_align(input logic [31:0] a, input int off);
    return a & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Refill staging buffer: one 32-bit slot per bank, written by beat index.
// The whole line is always visible on line_o.
module icache_line_buffer #(
  parameter int BANK = 8,
  parameter int BW   = $clog2(BANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [BW-1:0]     idx_i,
  input  logic [31:0]       data_i,
  output logic [BANK*32-1:0] line_o
);

  logic [31:0] slot_q [BANK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK; i++) slot_q[i] <= '0;
    end else if (we_i) begin
      slot_q[idx_i] <= data_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < BANK; i++) line_o[i*32 +: 32] = slot_q[i];
  end

endmodule

// File: rtl/icache_refill.sv
// Instruction cache refill unit: fetches a missing line beat by beat,
// writes it into a round-robin victim way, and sweeps all sets on flush.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ICACHE_WAY       = icache_refill_pkg::ICACHE_WAY,
  parameter int ICACHE_BANK      = icache_refill_pkg::ICACHE_BANK,
  parameter int ICACHE_SET_WIDTH = icache_refill_pkg::ICACHE_SET_WIDTH,
  parameter int ICACHE_TAG       = icache_refill_pkg::ICACHE_TAG
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                miss_valid,
  output logic                                miss_ready,
  input  logic [31:0]                         miss_addr,
  input  logic                                flush,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [31:0]                         mem_req_addr,
  input  logic                                mem_rsp_valid,
  input  logic [31:0]                         mem_rsp_data,
  output logic [ICACHE_WAY-1:0]               way_we,
  output logic                                tagv_we,
  output logic [ICACHE_SET_WIDTH-1:0]         tagv_windex,
  output logic [ICACHE_TAG:0]                 tagv_wdata,
  output logic [ICACHE_BANK-1:0]              we,
  output logic [ICACHE_BANK*ICACHE_SET_WIDTH-1:0] windex,
  output logic [ICACHE_BANK*32-1:0]           wdata,
  output logic                                refill_valid,
  output logic [31:0]                         refill_addr,
  output logic [ICACHE_BANK*32-1:0]           refill_data,
  output logic                                busy
);

  localparam int OFF = $clog2(ICACHE_BANK * 4);
  localparam int BW  = $clog2(ICACHE_BANK);
  localparam int VW  = (ICACHE_WAY > 1) ? $clog2(ICACHE_WAY) : 1;

  state_e                      state_q;
  logic [31:0]                 addr_q;
  logic [BW-1:0]               beat_q;
  logic [ICACHE_SET_WIDTH-1:0] set_q;
  logic [VW-1:0]               victim_q;
  logic                        flush_pend_q;

  logic                        flush_seen;
  logic                        buf_we;
  logic [ICACHE_BANK*32-1:0]   line;
  logic [ICACHE_SET_WIDTH-1:0] idx;
  logic [ICACHE_TAG-1:0]       tag;

  // A flush pulse counts as pending in the very cycle it arrives.
  assign flush_seen = flush_pend_q | flush;
  assign buf_we     = (state_q == ST_RECV) & mem_rsp_valid;
  assign idx        = addr_q[OFF +: ICACHE_SET_WIDTH];
  assign tag        = addr_q[OFF+ICACHE_SET_WIDTH +: ICACHE_TAG];

  icache_line_buffer #(
    .BANK (ICACHE_BANK),
    .BW   (BW)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .we_i   (buf_we),
    .idx_i  (beat_q),
    .data_i (mem_rsp_data),
    .line_o (line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      set_q        <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (flush) flush_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (flush_seen) begin
            state_q <= ST_FLUSH;
            set_q   <= '0;
          end else if (miss_valid) begin
            addr_q  <= line_align(miss_addr, OFF);
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_q <= ST_RECV;
            beat_q  <= '0;
          end
        end
        ST_RECV: begin
          if (mem_rsp_valid) begin
            beat_q <= beat_q + BW'(1);
            if (beat_q == BW'(ICACHE_BANK - 1)) state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          victim_q <= (victim_q == VW'(ICACHE_WAY - 1)) ? '0 : victim_q + VW'(1);
          set_q    <= '0;
          state_q  <= flush_seen ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: begin
          // Clearing last lets it override a pulse landing on the final set.
          if (set_q == {ICACHE_SET_WIDTH{1'b1}}) begin
            set_q        <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            set_q <= set_q + ICACHE_SET_WIDTH'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    miss_ready    = (state_q == ST_IDLE) & ~flush_seen;
    busy          = (state_q != ST_IDLE);
    mem_req_valid = (state_q == ST_REQ);
    mem_req_addr  = addr_q;
    way_we        = '0;
    tagv_we       = 1'b0;
    tagv_windex   = idx;
    tagv_wdata    = '0;
    we            = '0;
    windex        = {ICACHE_BANK{idx}};
    wdata         = line;
    refill_valid  = 1'b0;
    refill_addr   = addr_q;
    refill_data   = line;
    case (state_q)
      ST_WRITE: begin
        way_we       = ICACHE_WAY'(1) << victim_q;
        tagv_we      = 1'b1;
        tagv_wdata   = {1'b1, tag};
        we           = '1;
        refill_valid = 1'b1;
      end
      ST_FLUSH: begin
        way_we      = '1;
        tagv_we     = 1'b1;
        tagv_windex = set_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameters SHALL be: ICACHE_WAY default 4, ways per set; ICACHE_BANK default 8, 32-bit banks per line; ICACHE_SET_WIDTH default 6, index bits; ICACHE_TAG default 21, tag bits (32 - SET_WIDTH - log2(BANK*4)).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- miss_valid  in  1  fetch stage reports a miss
- miss_ready  out  1  refill unit accepts a miss
- miss_addr  in  32  missing fetch address
- flush  in  1  one-cycle pulse requesting invalidation of all lines
- mem_req_valid  out  1  line read request
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  32  line-aligned address
- mem_rsp_valid  in  1  one 32-bit beat valid; no backpressure
- mem_rsp_data  in  32  beat data, bank 0 first
- way_we  out  ICACHE_WAY  one-hot way select for all writes
- tagv_we  out  1  tag/valid write strobe
- tagv_windex  out  SET_WIDTH  tag/valid write index
- tagv_wdata  out  TAG+1  {valid, tag}
- we  out  ICACHE_BANK  data-bank write strobes
- windex  out  BANK*SET_WIDTH  per-bank write index
- wdata  out  BANK*32  per-bank write data
- refill_valid  out  1  one-cycle pulse: line written
- refill_addr  out  32  line-aligned address of written line
- refill_data  out  BANK*32  written line, for fetch bypass
- busy  out  1  state is not IDLE

Function
REQ-003 FSM states SHALL be IDLE, REQ, RECV, WRITE, FLUSH.
REQ-004 miss_ready SHALL be 1 only in IDLE with no pending flush; a miss is accepted when miss_valid and miss_ready are both 1.
REQ-005 Accepting a miss SHALL latch miss_addr with bits [log2(BANK*4)-1:0] cleared, then go to REQ on the next cycle.
REQ-006 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL be the latched address; mem_req_valid SHALL stay 1 until mem_req_ready, then the FSM SHALL go to RECV.
REQ-007 In RECV, each mem_rsp_valid beat SHALL be stored into line buffer slot beat_cnt, then beat_cnt SHALL increment; beat_cnt width is log2(BANK).
REQ-008 When the ICACHE_BANK-th beat is stored, the FSM SHALL go to WRITE. mem_rsp_valid outside RECV SHALL be ignored.
REQ-009 WRITE SHALL last exactly one cycle. In that cycle:
- we = all ones and tagv_we = 1
- way_we = one-hot of the victim counter
- every windex slot and tagv_windex = latched index
- tagv_wdata = {1, latched tag}
- wdata = refill_data = line buffer
- refill_valid = 1, refill_addr = latched address
REQ-010 The victim counter (log2(WAY) bits) SHALL increment at the end of WRITE and wrap from WAY-1 to 0.
REQ-011 After WRITE, the FSM SHALL go to FLUSH if a flush is pending, otherwise to IDLE.
REQ-012 A flush pulse in any state SHALL set a pending bit. In IDLE, a pending flush SHALL take priority over a same-cycle miss, and that miss SHALL NOT be accepted.
REQ-013 FLUSH SHALL sweep set_cnt from 0 to 2^SET_WIDTH-1, one set per cycle, with:
- tagv_we = 1, way_we = all ones
- tagv_windex = set_cnt, tagv_wdata = 0, we = 0
After the last set, the FSM SHALL clear the pending bit and go to IDLE. A flush pulse arriving during FLUSH SHALL be absorbed.
REQ-014 Outside WRITE and FLUSH, we, tagv_we, way_we and refill_valid SHALL be 0.

Reset
REQ-015 Asserting rst SHALL take effect immediately, including mid-refill or mid-flush, forcing:
- state IDLE
- beat_cnt, set_cnt and victim counter 0
- flush pending 0
- latched address and line buffer 0
- every output 0, except miss_ready = 1
REQ-016 A refill in progress when rst is asserted SHALL be abandoned with no array write.

Structure
REQ-017 The FSM state enum and the ICACHE_* widths/offset constants SHALL live in the shared frontend package/defines.
REQ-018 The design SHALL have one sub-module, icache_line_buffer: BANK x 32 registers with write-by-beat-index and a full-line read.

Verification
REQ-019 Miss 0x0000_1234, mem_req_ready after 2 cycles, 8 beats 0x100..0x107 -> mem_req_addr 0x0000_1220; WRITE with tagv_windex 0x11, tagv_wdata {1, 0x000002}, way_we 0001, wdata[0] = 0x100.
REQ-020 Four back-to-back misses -> way_we 0001, 0010, 0100, 1000; a fifth miss -> way_we 0001.
REQ-021 Flush in IDLE -> 64 cycles with tagv_we = 1 and tagv_windex 0..63; miss_ready = 0 throughout; IDLE afterwards.
REQ-022 Flush during RECV beat 3 -> refill completes normally, then FLUSH starts the cycle after WRITE.
REQ-023 rst asserted after beat 5 -> no we or tagv_we pulse; the next miss refills a full 8 beats into way 0.
REQ-024 Flush and miss_valid in the same IDLE cycle -> miss not accepted; FLUSH entered.
